// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// stage indices into the hold/flush vectors, the canonical control patterns,
// and the priority-ordered RUN-state decision used by several FSM states.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_TRAP     = 2'd3
    } state_e;

    // Bit positions inside hold_o / flush_o
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_WB    = 4;
    localparam int NSTG      = 5;

    localparam logic [NSTG-1:0] HOLD_ALL    = 5'b11111;  // bus wait: freeze everything
    localparam logic [NSTG-1:0] HOLD_MC     = 5'b01111;  // multi-cycle EX: freeze up to EX/MEM
    localparam logic [NSTG-1:0] FLUSH_MC    = 5'b10000;  // ...and drain a bubble into WB
    localparam logic [NSTG-1:0] FLUSH_TRAP  = 5'b11110;  // trap: kill every in-flight instr
    localparam logic [NSTG-1:0] FLUSH_JUMP  = 5'b00110;  // taken jump: kill IF/ID and ID/EX
    localparam logic [NSTG-1:0] HOLD_LDU    = 5'b00011;  // load-use: replay ID
    localparam logic [NSTG-1:0] FLUSH_LDU   = 5'b00100;  // ...with a bubble into EX
    localparam logic [NSTG-1:0] FLUSH_REDIR = 5'b00010;  // redirect fetch bubble after trap

    typedef struct packed {
        logic [NSTG-1:0] hold;
        logic [NSTG-1:0] flush;
        state_e          next;
        logic            to_load;   // reload the multi-cycle timeout counter
    } ctrl_t;

    // Priority-ordered RUN decision; the enables let other states reuse a subset.
    function automatic ctrl_t run_rules(input logic en_trap, input logic en_mem,
                                        input logic en_mc, input logic trap,
                                        input logic mem_busy, input logic mc_busy,
                                        input logic jump, input logic ld_use);
        ctrl_t c;
        c.hold    = '0;
        c.flush   = '0;
        c.next    = ST_RUN;
        c.to_load = 1'b0;
        if (en_trap && trap) begin
            c.flush = FLUSH_TRAP;
            c.next  = ST_TRAP;
        end else if (en_mem && mem_busy) begin
            c.hold = HOLD_ALL;
            c.next = ST_MEM_WAIT;
        end else if (en_mc && mc_busy) begin
            c.hold    = HOLD_MC;
            c.flush   = FLUSH_MC;
            c.next    = ST_MC_WAIT;
            c.to_load = 1'b1;
        end else if (jump) begin
            // A same-cycle load-use belongs to the wrong path, so jump wins.
            c.flush = FLUSH_JUMP;
        end else if (ld_use) begin
            c.hold  = HOLD_LDU;
            c.flush = FLUSH_LDU;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count enabled cycles, holding at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. hold_o/flush_o are
// combinational from the FSM state and the hazard inputs; the FSM sequences
// bus waits, multi-cycle EX ops (with a timeout) and trap redirects.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use_hazard_i,
    input  logic             jump_i,
    input  logic             mc_start_i,
    input  logic             mc_done_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             trap_i,
    output logic [4:0]       hold_o,
    output logic [4:0]       flush_o,
    output logic [1:0]       state_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int TO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(MC_TIMEOUT - 1);

    state_e          state_q;
    logic [TO_W-1:0] to_cnt_q;
    ctrl_t           ctrl;
    logic            to_dec;
    logic            set_timeout;
    logic            mem_busy;
    logic            mc_busy;

    assign mem_busy = mem_req_i & ~mem_ready_i;
    assign mc_busy  = mc_start_i & ~mc_done_i;

    // Next-state and hold/flush decode from current state and hazard inputs
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        ctrl        = '{hold: '0, flush: '0, next: state_q, to_load: 1'b0};
        to_dec      = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            ST_RUN: begin
                ctrl = run_rules(1'b1, 1'b1, 1'b1, trap_i, mem_busy, mc_busy,
                                 jump_i, ld_use_hazard_i);
            end
            ST_MC_WAIT: begin
                if (trap_i || mc_done_i || (to_cnt_q == '0)) begin
                    // Trap takes priority; otherwise release and resolve jump/load-use.
                    ctrl = run_rules(1'b1, 1'b0, 1'b0, trap_i, mem_busy, mc_busy,
                                     jump_i, ld_use_hazard_i);
                    set_timeout = ~trap_i & ~mc_done_i;
                end else begin
                    ctrl.hold  = HOLD_MC;
                    ctrl.flush = FLUSH_MC;
                    to_dec     = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready_i) begin
                    // Traps are deferred until the bus access completes.
                    ctrl.hold = HOLD_ALL;
                end else begin
                    ctrl = run_rules(1'b1, 1'b0, 1'b1, trap_i, mem_busy, mc_busy,
                                     jump_i, ld_use_hazard_i);
                end
            end
            ST_TRAP: begin
                ctrl.flush = FLUSH_REDIR;
                ctrl.next  = ST_RUN;
            end
            default: begin
                ctrl.next = ST_RUN;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= ctrl.next;
        end
    end

    // Multi-cycle timeout counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q     <= '0;
            mc_timeout_o <= 1'b0;
        end else begin
            if (ctrl.to_load) begin
                to_cnt_q <= TO_LOAD;
            end else if (to_dec) begin
                to_cnt_q <= to_cnt_q - 1'b1;
            end
            if (set_timeout) begin
                mc_timeout_o <= 1'b1;
            end
        end
    end

    // Controls are forced inactive while reset is asserted
    assign hold_o  = rst_n ? ctrl.hold  : '0;
    assign flush_o = rst_n ? ctrl.flush : '0;
    assign state_o = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hold_o[STG_PC]),
        .cnt   (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle RUN
// vectors plus hand-written multi-cycle sequences, all checked via a
// scoreboard queue of expected hold/flush/next-state records.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W  = 4;
    localparam int MC_TO  = 8;

    logic             clk;
    logic             rst_n;
    logic             ld_use_hazard_i;
    logic             jump_i;
    logic             mc_start_i;
    logic             mc_done_i;
    logic             mem_req_i;
    logic             mem_ready_i;
    logic             trap_i;
    logic [4:0]       hold_o;
    logic [4:0]       flush_o;
    logic [1:0]       state_o;
    logic             mc_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Input order: trap, mem_req, mem_ready, mc_start, mc_done, jump, ld_use
    typedef struct packed {
        logic trap;
        logic mem_req;
        logic mem_ready;
        logic mc_start;
        logic mc_done;
        logic jump;
        logic ld_use;
    } in_t;

    typedef struct packed {
        logic [4:0] hold;
        logic [4:0] flush;
        logic [1:0] state;
    } exp_t;

    typedef struct {
        in_t   in;
        exp_t  exp;
        string name;
    } vec_t;

    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_LDU   = 7'b0000001;
    localparam logic [6:0] I_JUMP  = 7'b0000010;
    localparam logic [6:0] I_DONE  = 7'b0000100;
    localparam logic [6:0] I_MC    = 7'b0001000;
    localparam logic [6:0] I_RDY   = 7'b0010000;
    localparam logic [6:0] I_MEM   = 7'b0100000;
    localparam logic [6:0] I_TRAP  = 7'b1000000;

    vec_t vecs[10];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl #(.MC_TIMEOUT(MC_TO), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ld_use_hazard_i (ld_use_hazard_i),
        .jump_i          (jump_i),
        .mc_start_i      (mc_start_i),
        .mc_done_i       (mc_done_i),
        .mem_req_i       (mem_req_i),
        .mem_ready_i     (mem_ready_i),
        .trap_i          (trap_i),
        .hold_o          (hold_o),
        .flush_o         (flush_o),
        .state_o         (state_o),
        .mc_timeout_o    (mc_timeout_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        in_t s;
        s               = in_t'(v);
        trap_i          = s.trap;
        mem_req_i       = s.mem_req;
        mem_ready_i     = s.mem_ready;
        mc_start_i      = s.mc_start;
        mc_done_i       = s.mc_done;
        jump_i          = s.jump;
        ld_use_hazard_i = s.ld_use;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(I_NONE);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, check combinational controls, then state after the edge
    task automatic step(input logic [6:0] v, input logic [4:0] eh, input logic [4:0] ef,
                        input logic [1:0] es, input string nm);
        exp_t e;
        exp_t got;
        @(negedge clk);
        drive(v);
        e.hold  = eh;
        e.flush = ef;
        e.state = es;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        check({nm, " hold"}, 32'(hold_o), 32'(got.hold));
        check({nm, " flush"}, 32'(flush_o), 32'(got.flush));
        @(posedge clk);
        #1;
        check({nm, " state"}, 32'(state_o), 32'(got.state));
    endtask

    task automatic set_vec(input int i, input logic [6:0] v, input logic [4:0] h,
                           input logic [4:0] f, input logic [1:0] s, input string nm);
        vecs[i].in        = in_t'(v);
        vecs[i].exp.hold  = h;
        vecs[i].exp.flush = f;
        vecs[i].exp.state = s;
        vecs[i].name      = nm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        logic released;

        rst_n = 1'b0;
        drive(I_NONE);

        set_vec(0, I_NONE,                      5'b00000, 5'b00000, 2'd0, "idle");
        set_vec(1, I_JUMP | I_LDU,              5'b00000, 5'b00110, 2'd0, "jump beats ldu");
        set_vec(2, I_LDU,                       5'b00011, 5'b00100, 2'd0, "ldu");
        set_vec(3, I_JUMP,                      5'b00000, 5'b00110, 2'd0, "jump");
        set_vec(4, 7'b1111011,                  5'b00000, 5'b11110, 2'd3, "trap first");
        set_vec(5, I_MEM | I_MC | I_JUMP,       5'b11111, 5'b00000, 2'd2, "mem busy");
        set_vec(6, I_MEM | I_RDY | I_JUMP,      5'b00000, 5'b00110, 2'd0, "mem ready");
        set_vec(7, I_MC | I_JUMP,               5'b01111, 5'b10000, 2'd1, "mc start");
        set_vec(8, I_MC | I_DONE | I_LDU,       5'b00011, 5'b00100, 2'd0, "mc same-cycle done");
        set_vec(9, I_MEM | I_TRAP,              5'b00000, 5'b11110, 2'd3, "trap over mem");

        // Reset state, checked while reset is held
        #3;
        check("reset hold", 32'(hold_o), 32'd0);
        check("reset flush", 32'(flush_o), 32'd0);
        check("reset state", 32'(state_o), 32'd0);
        check("reset timeout", 32'(mc_timeout_o), 32'd0);
        check("reset stall_cnt", 32'(stall_cnt_o), 32'd0);

        // Table of single-cycle RUN vectors, each from a fresh reset
        for (int i = 0; i < 10; i++) begin
            do_reset();
            step(vecs[i].in, vecs[i].exp.hold, vecs[i].exp.flush, vecs[i].exp.state,
                 vecs[i].name);
        end

        // Load-use for one cycle bumps the stall counter once
        do_reset();
        step(I_LDU, 5'b00011, 5'b00100, 2'd0, "ldu seq");
        check("ldu stall_cnt", 32'(stall_cnt_o), 32'd1);

        // Bus wait: 3 held cycles, trap deferred while waiting
        do_reset();
        step(I_MEM,          5'b11111, 5'b00000, 2'd2, "mem c1");
        step(I_MEM | I_TRAP, 5'b11111, 5'b00000, 2'd2, "mem c2 trap deferred");
        step(I_MEM,          5'b11111, 5'b00000, 2'd2, "mem c3");
        step(I_MEM | I_RDY,  5'b00000, 5'b00000, 2'd0, "mem c4 ready");
        check("mem stall_cnt", 32'(stall_cnt_o), 32'd3);

        // Multi-cycle op completing on the 5th cycle
        do_reset();
        step(I_MC, 5'b01111, 5'b10000, 2'd1, "mc c1");
        for (int i = 2; i <= 4; i++) begin
            step(I_MC, 5'b01111, 5'b10000, 2'd1, $sformatf("mc c%0d", i));
        end
        step(I_MC | I_DONE, 5'b00000, 5'b00000, 2'd0, "mc c5 done");
        check("mc no timeout", 32'(mc_timeout_o), 32'd0);
        check("mc stall_cnt", 32'(stall_cnt_o), 32'd4);

        // Multi-cycle op that never completes: forced release after timeout
        do_reset();
        held     = 0;
        released = 1'b0;
        for (int i = 0; i < 20 && !released; i++) begin
            @(negedge clk);
            drive(I_MC);
            #1;
            if (hold_o == 5'b00000) released = 1'b1;
            else held++;
            @(posedge clk);
            #1;
        end
        check("timeout released", 32'(released), 32'd1);
        check("timeout held cycles", 32'(held), 32'(MC_TO));
        check("timeout state", 32'(state_o), 32'd0);
        check("timeout flag", 32'(mc_timeout_o), 32'd1);
        step(I_NONE, 5'b00000, 5'b00000, 2'd0, "post timeout idle");
        step(I_JUMP, 5'b00000, 5'b00110, 2'd0, "post timeout jump");
        check("timeout flag sticky", 32'(mc_timeout_o), 32'd1);

        // Trap during MC_WAIT, redirect bubble, then async reset mid bus-wait
        do_reset();
        check("reset clears timeout", 32'(mc_timeout_o), 32'd0);
        step(I_MC,          5'b01111, 5'b10000, 2'd1, "trap seq mc");
        step(I_MC | I_TRAP, 5'b00000, 5'b11110, 2'd3, "trap in mc");
        step(I_NONE,        5'b00000, 5'b00010, 2'd0, "trap redirect");
        step(I_MEM,         5'b11111, 5'b00000, 2'd2, "enter mem wait");
        @(negedge clk);
        drive(I_MEM);
        #1;
        check("pre-reset hold", 32'(hold_o), 32'h1f);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset hold", 32'(hold_o), 32'd0);
        check("async reset flush", 32'(flush_o), 32'd0);
        check("async reset state", 32'(state_o), 32'd0);
        check("async reset stall_cnt", 32'(stall_cnt_o), 32'd0);
        drive(I_NONE);
        #1;
        rst_n = 1'b1;

        // Stall counter saturates at all-ones
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(I_MEM);
        end
        @(posedge clk);
        #1;
        check("stall_cnt saturates", 32'(stall_cnt_o), 32'((1 << CNT_W) - 1));
        @(negedge clk);
        drive(I_NONE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core pipeline. Drives per-register hold and flush (bubble) controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Resolves load-use hazards, taken jumps, bus wait states, multi-cycle EX ops (divider) and trap redirects. A small FSM sequences the multi-cycle waits.

Parameters:
MC_TIMEOUT, 64, max cycles spent in MC_WAIT before forced release (≥1)
CNT_W, 32, width of the stall performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ld_use_hazard_i  in  1  ID instr consumes the result of a load currently in EX
jump_i  in  1  EX resolved a taken branch/jump this cycle
mc_start_i  in  1  EX holds a multi-cycle op (level, held until done)
mc_done_i  in  1  multi-cycle unit result valid this cycle
mem_req_i  in  1  MEM stage has a bus access in flight
mem_ready_i  in  1  bus completes MEM access this cycle
trap_i  in  1  take exception/interrupt (level, source holds until taken)
hold_o  out  5  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB: keep value
flush_o  out  5  same indexing: load bubble (bit0 always 0)
state_o  out  2  current FSM state
mc_timeout_o  out  1  sticky: MC_TIMEOUT expired
stall_cnt_o  out  CNT_W  cycles with hold_o[0]=1, saturating

Behaviour:
- Reset (rst_n low, async): state=RUN, timeout cnt=0, mc_timeout_o=0, stall_cnt_o=0. hold_o/flush_o gated to 0 while rst_n low.
- hold_o/flush_o are combinational (zero latency) from state + inputs. State and counters update on posedge clk.
- Never assert hold and flush on the same bit.
- States: RUN=0, MC_WAIT=1, MEM_WAIT=2, TRAP=3.
- RUN, first match wins:
  1. trap_i: flush=11110, hold=0 -> TRAP
  2. mem_req_i & ~mem_ready_i: hold=11111 -> MEM_WAIT
  3. mc_start_i & ~mc_done_i: hold=01111, flush=10000 -> MC_WAIT; timeout cnt loads MC_TIMEOUT-1
  4. jump_i: flush=00110
  5. ld_use_hazard_i: hold=00011, flush=00100
  6. else: all 0
- Jump and load-use in the same cycle: jump wins, because the load-use instr is wrong-path.
- MC_WAIT:
  - trap_i: same as RUN rule 1.
  - mc_done_i: release, evaluate RUN rules 4-6 -> RUN.
  - timeout cnt==0: set mc_timeout_o, release as above -> RUN.
  - else: hold=01111, flush=10000, cnt decrements.
- MEM_WAIT:
  - ~mem_ready_i: hold=11111; trap_i ignored (deferred).
  - mem_ready_i: evaluate RUN rules 1, 3-6 -> RUN or next state per that rule.
- TRAP: flush=00010 (1-cycle redirect fetch bubble), hold=0 -> RUN unconditionally.
- stall_cnt_o: +1 each cycle hold_o[0]=1, saturates at all-ones. mc_timeout_o is cleared only by reset.
- Reset asserted mid-wait: immediate return to RUN, no pending state retained.

Decomposition:
- Shared core package holds:
  - state encodings (RUN/MC_WAIT/MEM_WAIT/TRAP)
  - stage index constants (STG_PC=0..STG_WB=4)
  - common hold/flush vector constants
- One sub-module, sat_counter (parameterised width, enable, saturating), used for stall_cnt_o.
- Timeout counter stays inline.

Test Plan:
- jump_i=1 & ld_use_hazard_i=1 in RUN -> same cycle hold=00000, flush=00110; state stays RUN.
- ld_use_hazard_i=1 for one cycle -> hold=00011, flush=00100, stall_cnt 0->1.
- mem_req_i=1, mem_ready_i low 3 cycles then high -> hold=11111 for 3 cycles (state RUN, MEM_WAIT, MEM_WAIT), 0 on 4th, stall_cnt_o=3, state back to RUN.
- mc_start_i=1, mc_done_i on 5th cycle -> 4 cycles of hold=01111/flush=10000, release on done, mc_timeout_o=0.
- MC_TIMEOUT=8, mc_done_i never -> 8 held cycles in MC_WAIT after entry, forced release, mc_timeout_o=1 and stays 1.
- trap_i during MC_WAIT -> flush=11110, then TRAP cycle flush=00010, then RUN; then async rst_n low mid MEM_WAIT -> outputs 0, state_o=0 without waiting for clk.
